montgomery_multiplier: RTL and testbench

- Sequential radix-2 Montgomery modular multiplier: S = A·B·R⁻¹ mod M, with R = 2^BITS.
- Core building block for the RSA modular-exponentiation datapath; one product per go/done handshake.
- Bit-serial: one multiplier bit of A per clock, then a final conditional subtraction.

---
 rtl/montgomery_multiplier_pkg.sv | 26 ++
 rtl/montgomery_multiplier_step.sv | 27 ++
 rtl/montgomery_multiplier.sv | 122 ++++++++++++
 tb/tb_montgomery_multiplier.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/montgomery_multiplier_pkg.sv
// Shared constants, FSM state encoding and width helper for the Montgomery multiplier.
package montgomery_multiplier_pkg;

  localparam int BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width of a counter spanning 0..value-1, never narrower than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) begin
      width = width + 1;
    end
    if (width < 1) begin
      width = 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/montgomery_multiplier_step.sv
// One radix-2 Montgomery iteration: add B when the multiplier bit is set, add M to make
// the sum even, then halve. Purely combinational.
module montgomery_multiplier_step
  import montgomery_multiplier_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic [BITS+1:0] p,
  input  logic            a_bit,
  input  logic [BITS-1:0] b,
  input  logic [BITS-1:0] m,
  output logic [BITS+1:0] p_next
);

  logic [BITS+1:0] t;
  logic [BITS+1:0] u;
  logic            q;

  // With P < 2M and B < M every sum stays below 4M, so BITS+2 bits never overflow.
  always_comb begin
    t      = p + (a_bit ? {2'b00, b} : '0);
    q      = t[0];
    u      = t + (q ? {2'b00, m} : '0);
    p_next = u >> 1;
  end

endmodule

// File: rtl/montgomery_multiplier.sv
// Bit-serial Montgomery multiplier S = A*B*2^-BITS mod M with a four-phase go/done handshake.
// Optional MONTGOMERY_INPUT_CHECK_EN adds an err output that flags an even or too-small modulus.
module montgomery_multiplier
  import montgomery_multiplier_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] M,
  input  logic            go,
  output logic            done,
  output logic [BITS-1:0] S
`ifdef MONTGOMERY_INPUT_CHECK_EN
  ,
  output logic            err
`endif
);

  localparam int CW = clog2(BITS);

  state_t          state;
  state_t          state_nxt;
  logic [BITS-1:0] a_reg;
  logic [BITS-1:0] b_reg;
  logic [BITS-1:0] m_reg;
  logic [BITS+1:0] p_reg;
  logic [BITS+1:0] p_step;
  logic [BITS+1:0] p_diff;
  logic [CW-1:0]   i_reg;
  logic            last_iter;
  logic            p_ge_m;
  logic            m_bad;

  montgomery_multiplier_step #(
    .BITS (BITS)
  ) u_step (
    .p      (p_reg),
    .a_bit  (a_reg[i_reg]),
    .b      (b_reg),
    .m      (m_reg),
    .p_next (p_step)
  );

  assign last_iter = (i_reg == CW'(BITS - 1));
  assign p_diff    = p_reg - {2'b00, m_reg};
  assign p_ge_m    = (p_reg >= {2'b00, m_reg});

`ifdef MONTGOMERY_INPUT_CHECK_EN
  assign m_bad = ~M[0] | (M < BITS'(3));
`else
  assign m_bad = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = m_bad ? DONE : CALC;
      CALC:    if (last_iter) state_nxt = FINAL;
      FINAL:   state_nxt = DONE;
      DONE:    if (!go) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      m_reg <= '0;
      p_reg <= '0;
      i_reg <= '0;
      done  <= 1'b0;
      S     <= '0;
`ifdef MONTGOMERY_INPUT_CHECK_EN
      err   <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (go) begin
            a_reg <= A;
            b_reg <= B;
            m_reg <= M;
            p_reg <= '0;
            i_reg <= '0;
            // A rejected modulus skips straight to DONE with a zero result.
            if (m_bad) begin
              S    <= '0;
              done <= 1'b1;
`ifdef MONTGOMERY_INPUT_CHECK_EN
              err  <= 1'b1;
`endif
            end
          end
        end
        CALC: begin
          p_reg <= p_step;
          i_reg <= i_reg + CW'(1);
        end
        FINAL: begin
          S    <= p_ge_m ? p_diff[BITS-1:0] : p_reg[BITS-1:0];
          done <= 1'b1;
        end
        DONE: begin
          if (!go) begin
            done <= 1'b0;
`ifdef MONTGOMERY_INPUT_CHECK_EN
            err  <= 1'b0;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_multiplier.sv
// Directed self-checking bench for montgomery_multiplier (BITS=16) with hand-computed products.
module tb_montgomery_multiplier;

  localparam int BITS = 16;
  localparam int LAT  = BITS + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [BITS-1:0] A;
  logic [BITS-1:0] B;
  logic [BITS-1:0] M;
  logic            go;
  logic            done;
  logic [BITS-1:0] S;
`ifdef MONTGOMERY_INPUT_CHECK_EN
  logic            err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  montgomery_multiplier #(
    .BITS (BITS)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .M     (M),
    .go    (go),
    .done  (done),
    .S     (S)
`ifdef MONTGOMERY_INPUT_CHECK_EN
    ,
    .err   (err)
`endif
  );

  // Counts edges until done is seen; returns 0 if the budget runs out.
  task automatic wait_done(output int cyc);
    int n;
    cyc = 0;
    n   = 0;
    while (cyc == 0 && n < 64) begin
      @(posedge clk);
      #1;
      n = n + 1;
      if (done) cyc = n;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    go    = 1'b0;
    A     = '0;
    B     = '0;
    M     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %0b want 0", done);
    end
    checks++;
    if (S !== '0) begin
      errors++;
      $display("FAIL reset_s got %0d want 0", S);
    end
`ifdef MONTGOMERY_INPUT_CHECK_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %0b want 0", err);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    A  = 16'd1;
    B  = 16'd9;
    M  = 16'd11;
    go = 1'b1;
    @(posedge clk);
    wait_done(cyc);
    checks++;
    if (cyc !== LAT) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", cyc, LAT);
    end
    checks++;
    if (S !== 16'd1) begin
      errors++;
      $display("FAIL basic_s got %0d want 1", S);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || S !== 16'd1) begin
      errors++;
      $display("FAIL basic_hold got done=%0b s=%0d want done=1 s=1", done, S);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || S !== 16'd1) begin
      errors++;
      $display("FAIL basic_release got done=%0b s=%0d want done=0 s=1", done, S);
    end
  endtask

  task automatic test_vectors();
    logic [BITS-1:0] va [3];
    logic [BITS-1:0] vb [3];
    logic [BITS-1:0] vm [3];
    logic [BITS-1:0] vs [3];
    int cyc;
    va[0] = 16'd5;     vb[0] = 16'd7;     vm[0] = 16'd11;    vs[0] = 16'd10;
    va[1] = 16'd12;    vb[1] = 16'd12;    vm[1] = 16'd13;    vs[1] = 16'd9;
    va[2] = 16'd65534; vb[2] = 16'd65534; vm[2] = 16'd65535; vs[2] = 16'd1;
    for (int k = 0; k < 3; k++) begin
      A  = va[k];
      B  = vb[k];
      M  = vm[k];
      go = 1'b1;
      @(posedge clk);
      wait_done(cyc);
      checks++;
      if (cyc !== LAT) begin
        errors++;
        $display("FAIL vec%0d_latency got %0d want %0d", k, cyc, LAT);
      end
      checks++;
      if (S !== vs[k]) begin
        errors++;
        $display("FAIL vec%0d_s got %0d want %0d", k, S, vs[k]);
      end
      go = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d_release got %0b want 0", k, done);
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    A  = 16'd0;
    B  = 16'd9;
    M  = 16'd11;
    go = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    A = 16'd7;
    B = 16'd5;
    M = 16'd13;
    wait_done(cyc);
    checks++;
    if (cyc + 3 !== LAT) begin
      errors++;
      $display("FAIL b2b_latency got %0d want %0d", cyc + 3, LAT);
    end
    checks++;
    if (S !== 16'd0) begin
      errors++;
      $display("FAIL b2b_s got %0d want 0", S);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_go_drop();
    int cyc;
    A  = 16'd5;
    B  = 16'd7;
    M  = 16'd11;
    go = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    go = 1'b0;
    wait_done(cyc);
    checks++;
    if (cyc + 1 !== LAT) begin
      errors++;
      $display("FAIL drop_latency got %0d want %0d", cyc + 1, LAT);
    end
    checks++;
    if (S !== 16'd10) begin
      errors++;
      $display("FAIL drop_s got %0d want 10", S);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL drop_pulse got done=%0b want 0", done);
    end
  endtask

  task automatic test_reset_abort();
    int cyc;
    A  = 16'd12;
    B  = 16'd12;
    M  = 16'd13;
    go = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || S !== 16'd10) begin
      errors++;
      $display("FAIL abort_midcalc got done=%0b s=%0d want done=0 s=10", done, S);
    end
    reset = 1'b1;
    go    = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || S !== 16'd0) begin
      errors++;
      $display("FAIL abort_reset got done=%0b s=%0d want done=0 s=0", done, S);
    end
    reset = 1'b0;
    A     = 16'd1;
    B     = 16'd9;
    M     = 16'd11;
    go    = 1'b1;
    @(posedge clk);
    wait_done(cyc);
    checks++;
    if (cyc !== LAT || S !== 16'd1) begin
      errors++;
      $display("FAIL abort_rerun got lat=%0d s=%0d want lat=%0d s=1", cyc, S, LAT);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask

`ifdef MONTGOMERY_INPUT_CHECK_EN
  task automatic test_input_check();
    int cyc;
    A  = 16'd3;
    B  = 16'd4;
    M  = 16'd10;
    go = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b1 || err !== 1'b1 || S !== 16'd0) begin
      errors++;
      $display("FAIL check_even got done=%0b err=%0b s=%0d want 1 1 0", done, err, S);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL check_clear got done=%0b err=%0b want 0 0", done, err);
    end
    A  = 16'd5;
    B  = 16'd7;
    M  = 16'd11;
    go = 1'b1;
    @(posedge clk);
    wait_done(cyc);
    checks++;
    if (cyc !== LAT || err !== 1'b0 || S !== 16'd10) begin
      errors++;
      $display("FAIL check_odd got lat=%0d err=%0b s=%0d want %0d 0 10", cyc, err, S, LAT);
    end
    go = 1'b0;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_go_drop();
    test_reset_abort();
`ifdef MONTGOMERY_INPUT_CHECK_EN
    test_input_check();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
